// File: rtl/or4_response_checker.sv
// or4_response_checker
//   Receiving end of the OR4 stimulus sequencer. Each accepted i_valid strobe
//   latches the applied vector. The checker waits SETTLE_CYCLES cycles, then
//   samples the gate output i_f and compares it with the OR of the vector.
//   It keeps saturating error and check counters, a 16-entry coverage map and
//   a sticky overrun flag. o_done is raised once every vector has been covered.
//
//   Optional macro OR4_CHK_FIRST_FAIL_EN: records the first failing vector and
//   the gate output at that failure. Without the macro both outputs tie to 0
//   and no capture registers are built.
//
//   Handshake: i_valid is a one-cycle strobe with no ready/back-pressure. It is
//   accepted only in IDLE. In SETTLE or SAMPLE the vector is dropped and
//   o_overrun is set. In DONE it is silently ignored. i_clear has priority
//   over i_valid.
//
//   o_state_dbg exposes the FSM encoding: 0 IDLE, 1 SETTLE, 2 SAMPLE, 3 DONE.
//   SETTLE_CYCLES must be in 1..255.
module or4_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [3:0]           i_vec,
  input  logic                 i_f,
  input  logic                 i_clear,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [7:0]           o_chk_cnt,
  output logic [15:0]          o_cov,
  output logic                 o_overrun,
  output logic [3:0]           o_fail_vec,
  output logic                 o_fail_f,
  output logic [1:0]           o_state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]           CNT_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           vec_q, vec_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [7:0]           chk_q, chk_d;
  logic [15:0]          cov_q, cov_d;
  logic                 ovr_q, ovr_d;

  logic                 mismatch;
  logic [15:0]          cov_upd;

  // Only meaningful in SAMPLE: the gate output against the OR of the latched vector.
  assign mismatch = (i_f != (|vec_q));
  assign cov_upd  = cov_q | (16'd1 << vec_q);

  // Next-state and statistics update; clear overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    chk_d   = chk_q;
    cov_d   = cov_q;
    ovr_d   = ovr_q;
    if (i_clear) begin
      state_d = ST_IDLE;
      err_d   = '0;
      chk_d   = '0;
      cov_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            vec_d   = i_vec;
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (i_valid) ovr_d = 1'b1;
          if (cnt_q == 8'd0) state_d = ST_SAMPLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        ST_SAMPLE: begin
          if (i_valid) ovr_d = 1'b1;
          chk_d = (chk_q == 8'hFF) ? chk_q : chk_q + 8'd1;
          if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
          cov_d   = cov_upd;
          state_d = (cov_upd == 16'hFFFF) ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and statistics registers, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      chk_q   <= '0;
      cov_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      cov_q   <= cov_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = o_done && (err_q == '0) && !ovr_q;
  assign o_err_cnt   = err_q;
  assign o_chk_cnt   = chk_q;
  assign o_cov       = cov_q;
  assign o_overrun   = ovr_q;
  assign o_state_dbg = state_q;

`ifdef OR4_CHK_FIRST_FAIL_EN
  logic       fcap_q, fcap_d;
  logic [3:0] fvec_q, fvec_d;
  logic       ff_q, ff_d;

  // First-failure capture: the flag blocks overwrites until clear or reset.
  always_comb begin
    fcap_d = fcap_q;
    fvec_d = fvec_q;
    ff_d   = ff_q;
    if (i_clear) begin
      fcap_d = 1'b0;
      fvec_d = '0;
      ff_d   = 1'b0;
    end else if ((state_q == ST_SAMPLE) && mismatch && !fcap_q) begin
      fcap_d = 1'b1;
      fvec_d = vec_q;
      ff_d   = i_f;
    end
  end

  // First-failure capture registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcap_q <= 1'b0;
      fvec_q <= '0;
      ff_q   <= 1'b0;
    end else begin
      fcap_q <= fcap_d;
      fvec_q <= fvec_d;
      ff_q   <= ff_d;
    end
  end

  assign o_fail_vec = fvec_q;
  assign o_fail_f   = ff_q;
`else
  assign o_fail_vec = 4'h0;
  assign o_fail_f   = 1'b0;
`endif

endmodule
